fcvtws_ctrl: RTL and testbench
==============================

// Module: fcvtws_ctrl
// PURPOSE
//  Issue/collect stage around the 1-cycle fcvtws converter (float32 -> int32).
//  Takes FPU-dispatch operands on a valid/ready handshake, feeds fcvtws, fixes up
//  out-of-range inputs fcvtws cannot handle, and buffers results with their
//  destination tag in an in-order FIFO toward the writeback arbiter.
// PARAMETERS
//  TAG_W  5  width of the destination-register tag carried alongside each operand
//  DEPTH  4  result FIFO entries; power of 2, >=2; 1 op/cycle sustained needs DEPTH>=3
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rstn       in   1      synchronous reset, active-low
//  in_valid   in   1      operand valid
//  in_ready   out  1      operand accepted when in_valid && in_ready
//  in_x       in   32     IEEE-754 single operand
//  in_tag     in   TAG_W  destination tag
//  out_valid  out  1      FIFO head valid
//  out_ready  in   1      consumer pops head when out_valid && out_ready
//  out_y      out  32     signed int32 result
//  out_tag    out  TAG_W  tag of out_y
//  out_ovf    out  1      input was NaN/Inf or |x| >= 2^31 (except exactly -2^31)
//  busy       out  1      any op in flight or buffered
// BEHAVIOUR
//  - Reset (rstn=0 at edge): inflight, FIFO count, pointers cleared; out_valid=0,
//    out_y=0, out_tag=0, out_ovf=0, busy=0. in_ready=0 while rstn=0. Reset mid-op
//    discards in-flight and buffered results; nothing is emitted afterwards.
//  - in_ready = rstn && (inflight + count) < DEPTH; from registers only, never
//    from out_ready or in_valid.
//  - Accept at edge N: in_x drives fcvtws in the cycle before N; tag, sign, class
//    flags registered at N (inflight=1). At edge N+1 fixed-up result pushed to FIFO;
//    out_valid high after N+1 if FIFO was empty. Latency 2 edges, in order.
//  - Rounding is fcvtws's: ties away from zero (1.5->2, -2.5->-3); not RNE.
//  - Classification on in_x (e = in_x[30:23]), registered with the op:
//    e<=125 -> result 0 (fcvtws output ignored); e in 126..157 -> fcvtws output;
//    in_x==0xCF000000 -> 0x80000000, ovf=0; other e>=158 (incl. Inf/NaN) -> ovf=1,
//    value per CONFIGURATION. -0.0 and tiny negatives give 0x00000000.
//  - FIFO: push at N+1 for every inflight op; pop on out_valid&&out_ready.
//    Simultaneous push+pop: count unchanged, pointers both advance, wrap mod DEPTH.
//    Push when full cannot occur (credit rule); pop when empty ignored.
//  - out_y/out_tag/out_ovf stable while out_valid && !out_ready.
//  - busy = inflight || (count != 0).
// CONFIGURATION
//  FCVTWS_CTRL_SATURATE_EN defined: ovf ops give 0x7FFFFFFF if sign=0 or NaN,
//    0x80000000 if sign=1 (non-NaN).
//  Not defined: every ovf op gives 0x80000000. out_ovf identical in both builds.
// TESTING
//  1. Reset, then 0x3FC00000 (1.5), tag 3, out_ready=1 -> 2 edges later out_y=2,
//     out_tag=3, out_ovf=0; busy low one cycle after pop.
//  2. Back-to-back 0xC0200000, 0x3F000000, 0x3EFAE148, 0x80000000 -> in order
//     0xFFFFFFFD, 1, 0, 0; in_ready never drops with out_ready=1 (DEPTH=4).
//  3. 0xCF000000 -> 0x80000000 ovf=0; 0x4F000000 and 0x7FC00000 -> ovf=1, out_y
//     0x7FFFFFFF (SATURATE_EN) or 0x80000000 (not defined); 0xFF800000 -> 0x80000000.
//  4. out_ready=0, offer 6 ops tags 0..5 -> exactly 4 accepted, in_ready=0 after
//     4th; head held stable; release out_ready -> tags 0..3 drained in order, then
//     4,5 accepted.
//  5. Random out_ready toggling, 1000 ops vs. model -> no loss/dup/reorder; push+pop
//     same edge keeps count; pointer wrap exercised.
//  6. rstn low for 1 cycle with 1 inflight + 3 buffered -> out_valid=0, busy=0 next
//     cycle; no stale result appears; next op returns normally after 2 edges.

Source files
------------

// File: rtl/fcvtws_ctrl_if.sv
// Operand and result handshake bundle for the fcvtws issue/collect stage.
// Carries no state, so it adds no latency.
// Backpressure: in_ready throttles issue and out_ready throttles result drain.
interface fcvtws_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_x, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_x, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag, out_ovf, busy
  );
endinterface

// File: rtl/fcvtws_ctrl.sv
// Issue/collect stage around a 1-cycle float32->int32 converter with an in-order result FIFO.
// Latency: 2 edges from operand accept to FIFO head; optional macro FCVTWS_CTRL_SATURATE_EN.
// Backpressure: credit based; in_ready only while in-flight plus buffered ops < DEPTH.
module fcvtws_ctrl #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rstn,
  fcvtws_ctrl_if.slave io
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW:0]   DEPTH_C = DEPTH[CW:0];

  // Converter datapath and operand classification
  logic [7:0]  x_exp;
  logic [23:0] x_man;
  logic [4:0]  x_sh;
  logic [62:0] x_fix;
  logic [31:0] x_mag;
  logic [31:0] x_conv;
  logic        x_zero;
  logic        x_min;
  logic        x_big;
  logic        x_ovf_neg;
`ifdef FCVTWS_CTRL_SATURATE_EN
  logic        x_nan;
`endif

  // Stage register (the op between accept and FIFO push)
  logic             st_vld;
  logic [TAG_W-1:0] st_tag;
  logic [31:0]      st_conv;
  logic             st_zero;
  logic             st_min;
  logic             st_big;
  logic             st_ovf_neg;
  logic [31:0]      st_res;

  // Result FIFO
  logic [31:0]      mem_y   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic             mem_ovf [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW:0]      used;
  logic             accept;
  logic             push;
  logic             pop;
  logic             nonempty;

  // Fixed-point conversion: mantissa placed with 32 fraction bits, rounded half away from zero
  always_comb begin
    x_exp  = io.in_x[30:23];
    x_man  = {1'b1, io.in_x[22:0]};
    x_sh   = 5'(8'd157 - x_exp);
    x_fix  = {x_man, 39'd0} >> x_sh;
    x_mag  = {1'b0, x_fix[62:32]} + {31'd0, x_fix[31]};
    x_conv = io.in_x[31] ? (32'd0 - x_mag) : x_mag;
    x_zero = (x_exp <= 8'd125);
    x_min  = (io.in_x == 32'hCF00_0000);
    x_big  = (x_exp >= 8'd158) && !x_min;
`ifdef FCVTWS_CTRL_SATURATE_EN
    x_nan     = (x_exp == 8'hFF) && (io.in_x[22:0] != 23'd0);
    x_ovf_neg = io.in_x[31] && !x_nan;
`else
    x_ovf_neg = 1'b1;
`endif
  end

  assign used     = {1'b0, count} + {{CW{1'b0}}, st_vld};
  assign io.in_ready = rstn && (used < DEPTH_C);
  assign accept   = io.in_valid && io.in_ready;
  assign push     = st_vld;
  assign nonempty = (count != '0);
  assign pop      = nonempty && io.out_ready;

  // In-flight flag: one op per accept, retired into the FIFO on the following edge
  always_ff @(posedge clk) begin
    if (!rstn) st_vld <= 1'b0;
    else       st_vld <= accept;
  end

  // Capture converter output, tag and class flags with the accepted op
  always_ff @(posedge clk) begin
    if (accept) begin
      st_tag     <= io.in_tag;
      st_conv    <= x_conv;
      st_zero    <= x_zero;
      st_min     <= x_min;
      st_big     <= x_big;
      st_ovf_neg <= x_ovf_neg;
    end
  end

  // Fix up ranges the converter cannot represent
  always_comb begin
    st_res = st_conv;
    if (st_zero)     st_res = 32'd0;
    else if (st_min) st_res = 32'h8000_0000;
    else if (st_big) st_res = st_ovf_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // FIFO storage write; contents are only observed through count, so no reset
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem_y[wptr]   <= st_res;
      mem_tag[wptr] <= st_tag;
      mem_ovf[wptr] <= st_big;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  assign io.out_valid = nonempty;
  assign io.out_y     = nonempty ? mem_y[rptr]   : 32'd0;
  assign io.out_tag   = nonempty ? mem_tag[rptr] : '0;
  assign io.out_ovf   = nonempty ? mem_ovf[rptr] : 1'b0;
  assign io.busy      = st_vld || nonempty;
endmodule

// File: tb/tb_fcvtws_ctrl.sv
// Scoreboard bench for fcvtws_ctrl: randomized ops against a real-arithmetic reference model.
// Drives the bus through the interface; results are checked by a decoupled monitor.
// Backpressure exercised via fixed and random out_ready.
module tb_fcvtws_ctrl;
  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic rand_rdy = 1'b0;
  logic fixed_rdy = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  logic [31:0] specials [10] = '{32'h0000_0000, 32'h8000_0000, 32'hCF00_0000, 32'h4F00_0000,
                                 32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000, 32'hFFC0_0001,
                                 32'h4EFF_FFFF, 32'hBF00_0000};

  fcvtws_ctrl_if #(.TAG_W(5)) io ();

  fcvtws_ctrl #(.TAG_W(5), .DEPTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (io)
  );

  always #5 clk = ~clk;

  // Consumer ready: fixed level or random toggling, changed well after the edge
  always @(posedge clk) begin
    #2;
    io.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : fixed_rdy;
  end

  // Reference: exact real value of the float, rounded half away from zero
  function automatic exp_t model(input logic [31:0] x, input logic [4:0] tag);
    exp_t  r;
    int    e;
    real   mant;
    real   v;
    longint iv;
    logic  s;
    logic  nan;
    s     = x[31];
    e     = int'(x[30:23]);
    nan   = (e == 255) && (x[22:0] != 23'd0);
    r.tag = tag;
    r.ovf = 1'b0;
    r.y   = 32'd0;
    if (e == 255) begin
      r.ovf = 1'b1;
    end else begin
      mant = real'(x[22:0]) + ((e == 0) ? 0.0 : 8388608.0);
      v    = mant * (2.0 ** real'((e == 0) ? -149 : e - 150));
      if (s && v == 2147483648.0) r.y = 32'h8000_0000;
      else if (v >= 2147483648.0) r.ovf = 1'b1;
      else begin
        iv = $rtoi($floor(v + 0.5));
        if (s) iv = -iv;
        r.y = iv[31:0];
      end
    end
    if (r.ovf) begin
`ifdef FCVTWS_CTRL_SATURATE_EN
      r.y = (s && !nan) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
      r.y = 32'h8000_0000;
`endif
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] x;
    case ($urandom_range(0, 3))
      0: x = $urandom();
      1: x = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 160)), 23'($urandom())};
      2: x = specials[$urandom_range(0, 9)];
      default: x = {1'($urandom_range(0, 1)), 8'($urandom_range(126, 150)),
                    23'($urandom()) & (23'h7F_FFFF << $urandom_range(8, 22))};
    endcase
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: pop the scoreboard on every transfer, and check the head holds while stalled
  task automatic monitor();
    logic        hold = 1'b0;
    logic [31:0] hy = '0;
    logic [4:0]  ht = '0;
    logic        ho = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("hold_valid", 32'(io.out_valid), 32'd1);
        chk("hold_y", io.out_y, hy);
        chk("hold_tag", 32'(io.out_tag), 32'(ht));
        chk("hold_ovf", 32'(io.out_ovf), 32'(ho));
      end
      hold = 1'b0;
      if (io.out_valid === 1'b1) begin
        if (io.out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got y=%h tag=%0d, expected no output", io.out_y, io.out_tag);
          end else begin
            e = exp_q.pop_front();
            chk("out_y", io.out_y, e.y);
            chk("out_tag", 32'(io.out_tag), 32'(e.tag));
            chk("out_ovf", 32'(io.out_ovf), 32'(e.ovf));
          end
        end else begin
          hold = 1'b1;
          hy = io.out_y;
          ht = io.out_tag;
          ho = io.out_ovf;
        end
      end
    end
  endtask

  // Present one op and wait (bounded) for acceptance; returns cycles spent waiting
  task automatic send(input logic [31:0] x, input logic [4:0] tag, output int waited);
    waited = 0;
    io.in_valid = 1'b1;
    io.in_x = x;
    io.in_tag = tag;
    forever begin
      @(negedge clk);
      if (io.in_ready === 1'b1) begin
        exp_q.push_back(model(x, tag));
        break;
      end
      waited++;
      if (waited > 300) begin
        chk("accept_timeout", 32'(waited), 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || io.busy !== 1'b0) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("drain_done", 32'(c < 3000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int nxt;
    int cyc;
    logic [31:0] xs [6];
    rstn = 1'b0;
    io.in_valid = 1'b0;
    io.in_x = '0;
    io.in_tag = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(io.in_ready), 32'd0);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_out_y", io.out_y, 32'd0);
    chk("rst_out_tag", 32'(io.out_tag), 32'd0);
    chk("rst_out_ovf", 32'(io.out_ovf), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(io.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1.5 -> 2, two-edge latency, busy clears after the pop
    send(32'h3FC0_0000, 5'd3, w);
    @(negedge clk);
    chk("lat_not_yet", 32'(io.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(io.out_valid), 32'd1);
    chk("lat_y", io.out_y, 32'd2);
    @(negedge clk);
    chk("busy_after_pop", 32'(io.busy), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back issue never stalls with the consumer ready
    send(32'hC020_0000, 5'd1, w); chk("b2b_ready", 32'(w), 32'd0);
    send(32'h3F00_0000, 5'd2, w); chk("b2b_ready", 32'(w), 32'd0);
    send(32'h3EFA_E148, 5'd4, w); chk("b2b_ready", 32'(w), 32'd0);
    send(32'h8000_0000, 5'd5, w); chk("b2b_ready", 32'(w), 32'd0);
    drain();

    // Range boundaries and specials
    send(32'hCF00_0000, 5'd6, w);
    send(32'h4F00_0000, 5'd7, w);
    send(32'h7FC0_0000, 5'd8, w);
    send(32'hFF80_0000, 5'd9, w);
    send(32'hBFC0_0000, 5'd10, w);
    send(32'h4EFF_FFFF, 5'd11, w);
    drain();

    // Full credit window with the consumer stalled
    fixed_rdy = 1'b0;
    for (int i = 0; i < 6; i++) xs[i] = rand_x();
    nxt = 0;
    for (cyc = 0; cyc < 12 && nxt < 6; cyc++) begin
      io.in_valid = 1'b1;
      io.in_x = xs[nxt];
      io.in_tag = 5'(nxt);
      @(negedge clk);
      if (io.in_ready === 1'b1) begin
        exp_q.push_back(model(xs[nxt], 5'(nxt)));
        nxt++;
      end
      @(posedge clk);
      #1;
    end
    chk("full_accepted", 32'(nxt), 32'd4);
    chk("full_in_ready", 32'(io.in_ready), 32'd0);
    fixed_rdy = 1'b1;
    for (cyc = 0; cyc < 50 && nxt < 6; cyc++) begin
      io.in_valid = 1'b1;
      io.in_x = xs[nxt];
      io.in_tag = 5'(nxt);
      @(negedge clk);
      if (io.in_ready === 1'b1) begin
        exp_q.push_back(model(xs[nxt], 5'(nxt)));
        nxt++;
      end
      @(posedge clk);
      #1;
    end
    io.in_valid = 1'b0;
    chk("full_rest_accepted", 32'(nxt), 32'd6);
    drain();

    // Random consumer backpressure over many ops
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(rand_x(), 5'($urandom_range(0, 31)), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rand_rdy = 1'b0;

    // Reset with one op in flight and three buffered
    fixed_rdy = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(rand_x(), 5'(20 + i), w);
    chk("pre_rst_busy", 32'(io.busy), 32'd1);
    rstn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 32'(io.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    fixed_rdy = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
    chk("midrst_busy", 32'(io.busy), 32'd0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    send(32'hC060_0000, 5'd30, w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
